// File: rtl/elliptic_curve_structs.sv
// Shared curve types for the point-multiplication datapath and the issuer FSM state.
package elliptic_curve_structs;

  localparam int unsigned FIELD_W      = 8;
  localparam int unsigned SCALAR_WIDTH = 16;

  typedef struct packed {
    logic [FIELD_W-1:0] x;
    logic [FIELD_W-1:0] y;
  } curve_point_t;

  // (0,0) is never on the curve (b != 0), so it encodes the point at infinity.
  localparam curve_point_t inf_point = '{x: '0, y: '0};

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} issuer_state_t;

endpackage

// File: rtl/point_mul_issuer.sv
// Job-side driver for one start/done point-multiplication engine: trivial scalars
// are answered locally, everything else runs on the engine under a cycle timeout.
module point_mul_issuer
  import elliptic_curve_structs::*;
#(
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    Reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  curve_point_t            in_P,
  input  logic [SCALAR_WIDTH-1:0] in_k,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    eng_Reset,
  output curve_point_t            eng_P,
  output logic [SCALAR_WIDTH-1:0] eng_k,
  input  logic                    eng_Done,
  input  curve_point_t            eng_R,
  output logic                    out_valid,
  input  logic                    out_ready,
  output curve_point_t            out_R,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_err,
  output logic [CNT_W-1:0]        jobs_done,
  output logic [CNT_W-1:0]        jobs_err
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT);

  issuer_state_t    state;
  logic [TMR_W-1:0] timer;
  logic             accept;
  logic             handoff;

  // Ready depends only on registered state and downstream ready, never on in_valid.
  assign in_ready = (state == IDLE) || ((state == RESP) && out_ready);
  assign accept   = in_valid && in_ready;
  assign handoff  = (state == RESP) && out_ready;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      eng_Reset <= 1'b1;
      eng_P     <= inf_point;
      eng_k     <= '0;
      out_valid <= 1'b0;
      out_R     <= inf_point;
      out_tag   <= '0;
      out_err   <= 1'b0;
      jobs_done <= '0;
      jobs_err  <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (handoff) begin
            jobs_done <= jobs_done + CNT_W'(1);
            if (out_err) jobs_err <= jobs_err + CNT_W'(1);
          end
          if (accept) begin
            out_tag <= in_tag;
            if (in_k == '0) begin
              out_R     <= inf_point;
              out_err   <= 1'b0;
              out_valid <= 1'b1;
              state     <= RESP;
            end else if (in_k == SCALAR_WIDTH'(1)) begin
              out_R     <= in_P;
              out_err   <= 1'b0;
              out_valid <= 1'b1;
              state     <= RESP;
            end else begin
              eng_P     <= in_P;
              eng_k     <= in_k;
              timer     <= '0;
              out_valid <= 1'b0;
              state     <= START;
            end
          end else if (handoff) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        START: begin
          // Operands were registered on accept; this cycle keeps the engine in reset with them stable.
          eng_Reset <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          if (eng_Done) begin
            out_R     <= eng_R;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            eng_Reset <= 1'b1;
            state     <= RESP;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            out_R     <= inf_point;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            eng_Reset <= 1'b1;
            state     <= RESP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_point_mul_issuer.sv
// Bench for point_mul_issuer: table vectors, directed corner sequences and a random
// phase, all checked against an affine curve model over GF(97), y^2 = x^3 + 2x + 3.
module tb_point_mul_issuer;
  import elliptic_curve_structs::*;

  localparam int unsigned TAG_W   = 8;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 32;
  localparam int PR = 97;
  localparam int CA = 2;
  localparam curve_point_t G  = '{x: 8'd3,  y: 8'd6};
  localparam curve_point_t G2 = '{x: 8'd80, y: 8'd10};
  localparam curve_point_t G3 = '{x: 8'd80, y: 8'd87};

  logic clk = 1'b0;
  logic Reset_n;
  logic in_valid, in_ready;
  curve_point_t in_P;
  logic [SCALAR_WIDTH-1:0] in_k;
  logic [TAG_W-1:0] in_tag;
  logic eng_Reset;
  curve_point_t eng_P;
  logic [SCALAR_WIDTH-1:0] eng_k;
  logic eng_Done;
  curve_point_t eng_R;
  logic out_valid, out_ready;
  curve_point_t out_R;
  logic [TAG_W-1:0] out_tag;
  logic out_err;
  logic [CNT_W-1:0] jobs_done, jobs_err;

  always #5 clk = ~clk;

  point_mul_issuer #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .Reset_n(Reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_P(in_P), .in_k(in_k), .in_tag(in_tag),
    .eng_Reset(eng_Reset), .eng_P(eng_P), .eng_k(eng_k), .eng_Done(eng_Done), .eng_R(eng_R),
    .out_valid(out_valid), .out_ready(out_ready), .out_R(out_R), .out_tag(out_tag),
    .out_err(out_err), .jobs_done(jobs_done), .jobs_err(jobs_err)
  );

  // Golden curve arithmetic
  function automatic int f_inv(input int a);
    int r = 1;
    int b = a % PR;
    int e = PR - 2;
    while (e > 0) begin
      if (e % 2 == 1) r = (r * b) % PR;
      b = (b * b) % PR;
      e = e / 2;
    end
    return r;
  endfunction

  function automatic curve_point_t ref_add(input curve_point_t a, input curve_point_t b);
    int x1, y1, x2, y2, l, x3, y3;
    curve_point_t r;
    if (a == inf_point) return b;
    if (b == inf_point) return a;
    x1 = int'(a.x); y1 = int'(a.y); x2 = int'(b.x); y2 = int'(b.y);
    if (x1 == x2) begin
      if ((y1 + y2) % PR == 0) return inf_point;
      l = (((3 * x1 * x1 + CA) % PR) * f_inv((2 * y1) % PR)) % PR;
    end else begin
      l = (((y2 - y1 + PR) % PR) * f_inv((x2 - x1 + PR) % PR)) % PR;
    end
    x3 = (l * l - x1 - x2 + 2 * PR) % PR;
    y3 = (l * (x1 - x3 + PR) - y1 + PR) % PR;
    r.x = FIELD_W'(x3);
    r.y = FIELD_W'(y3);
    return r;
  endfunction

  function automatic curve_point_t ref_mul(input curve_point_t p, input logic [SCALAR_WIDTH-1:0] k);
    curve_point_t acc = inf_point;
    for (int i = SCALAR_WIDTH - 1; i >= 0; i--) begin
      acc = ref_add(acc, acc);
      if (k[i]) acc = ref_add(acc, p);
    end
    return acc;
  endfunction

  // Engine model: Done rises in the eng_delay-th cycle after reset drops (0 = never)
  int   eng_delay = 0;
  int   eng_cnt = 0;
  logic force_done = 1'b0;
  int   low_total = 0;

  always @(posedge clk) begin
    if (eng_Reset) eng_cnt <= 0;
    else           eng_cnt <= eng_cnt + 1;
  end

  always @(negedge clk) begin
    if (!eng_Reset) low_total <= low_total + 1;
  end

  always_comb begin
    eng_Done = force_done || (!eng_Reset && eng_delay > 0 && eng_cnt == eng_delay - 1);
    eng_R    = eng_Done ? ref_mul(eng_P, eng_k) : curve_point_t'(16'hBEEF);
  end

  int n_vec = 0;
  int n_err = 0;
  int exp_done = 0;
  int exp_errs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic issue(input curve_point_t p, input logic [SCALAR_WIDTH-1:0] k,
                       input logic [TAG_W-1:0] tag);
    int g = 0;
    in_valid = 1'b1; in_P = p; in_k = k; in_tag = tag;
    #1;
    while (!in_ready && g < 200) begin
      @(negedge clk); #1; g++;
    end
    chk("in_ready_seen", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk); lat++;
    end
    chk("out_valid_seen", 64'(out_valid), 64'd1);
  endtask

  task automatic pop_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    curve_point_t            p;
    logic [SCALAR_WIDTH-1:0] k;
    logic [TAG_W-1:0]        tag;
    int                      delay;
    curve_point_t            exp_r;
    logic                    exp_err;
    int                      exp_lat;
    int                      exp_low;
  } vec_t;

  typedef struct {
    curve_point_t     r;
    logic [TAG_W-1:0] tag;
    logic             err;
  } res_t;

  vec_t tbl[8];
  res_t q[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, base, d;
    logic acc;
    res_t e, got;

    tbl[0] = '{G,  16'd0,      8'h01, 0,  inf_point,                 1'b0, 1,  0};
    tbl[1] = '{G,  16'd1,      8'h02, 0,  G,                         1'b0, 1,  0};
    tbl[2] = '{G,  16'd2,      8'h11, 5,  G2,                        1'b0, 7,  5};
    tbl[3] = '{G,  16'd3,      8'h33, 1,  G3,                        1'b0, 3,  1};
    tbl[4] = '{G2, 16'd4,      8'h44, 16, G3,                        1'b0, 18, 16};
    tbl[5] = '{G,  16'd7,      8'h55, 0,  inf_point,                 1'b1, 18, 16};
    tbl[6] = '{G,  16'hFFFF,   8'hAA, 9,  ref_mul(G, 16'hFFFF),      1'b0, 11, 9};
    tbl[7] = '{G3, 16'd1,      8'hBB, 0,  G3,                        1'b0, 1,  0};

    Reset_n = 1'b0; in_valid = 1'b0; in_P = inf_point; in_k = '0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    Reset_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_eng_reset", 64'(eng_Reset), 64'd1);
    chk("rst_jobs_done", 64'(jobs_done), 64'd0);
    chk("rst_jobs_err", 64'(jobs_err), 64'd0);
    chk("rst_out_R", 64'(out_R), 64'(inf_point));
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_eng_P", 64'(eng_P), 64'(inf_point));
    chk("rst_eng_k", 64'(eng_k), 64'd0);

    // Done outside WAIT must be ignored
    force_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_done_ignored", 64'(out_valid), 64'd0);
    end
    force_done = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      base = low_total;
      eng_delay = tbl[i].delay;
      issue(tbl[i].p, tbl[i].k, tbl[i].tag);
      collect(lat);
      chk($sformatf("tbl%0d_R", i), 64'(out_R), 64'(tbl[i].exp_r));
      chk($sformatf("tbl%0d_tag", i), 64'(out_tag), 64'(tbl[i].tag));
      chk($sformatf("tbl%0d_err", i), 64'(out_err), 64'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].exp_lat));
      chk($sformatf("tbl%0d_eng_low_cycles", i), 64'(low_total - base), 64'(tbl[i].exp_low));
      pop_result();
      exp_done++;
      if (tbl[i].exp_err) exp_errs++;
      chk($sformatf("tbl%0d_jobs_done", i), 64'(jobs_done), 64'(exp_done));
      chk($sformatf("tbl%0d_jobs_err", i), 64'(jobs_err), 64'(exp_errs));
    end

    // Backpressure with a second job waiting, then back-to-back accept
    issue(G, 16'd0, 8'h61);
    in_valid = 1'b1; in_P = G; in_k = 16'd2; in_tag = 8'h62; eng_delay = 3; out_ready = 1'b0;
    repeat (10) begin
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_R", 64'(out_R), 64'(inf_point));
      chk("bp_out_tag", 64'(out_tag), 64'h61);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    exp_done++;
    collect(lat);
    chk("b2b_latency", 64'(lat), 64'd5);
    chk("b2b_R", 64'(out_R), 64'(G2));
    chk("b2b_tag", 64'(out_tag), 64'h62);
    chk("b2b_err", 64'(out_err), 64'd0);
    pop_result();
    exp_done++;
    chk("b2b_jobs_done", 64'(jobs_done), 64'(exp_done));

    // Reset in the middle of an engine job discards it
    eng_delay = 0;
    issue(G, 16'd3, 8'h99);
    repeat (4) @(negedge clk);
    Reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_eng_reset", 64'(eng_Reset), 64'd1);
    chk("midrst_jobs_done", 64'(jobs_done), 64'd0);
    @(negedge clk);
    Reset_n = 1'b1;
    exp_done = 0; exp_errs = 0; eng_delay = 5;
    repeat (20) begin
      @(negedge clk);
      chk("midrst_no_result", 64'(out_valid), 64'd0);
    end
    issue(G, 16'd3, 8'h22);
    collect(lat);
    chk("midrst_R", 64'(out_R), 64'(G3));
    chk("midrst_tag", 64'(out_tag), 64'h22);
    chk("midrst_latency", 64'(lat), 64'd7);
    pop_result();
    exp_done++;
    chk("midrst_jobs_done", 64'(jobs_done), 64'(exp_done));

    // Random traffic against an in-order scoreboard
    acc = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (acc) in_valid = 1'b0;
      if (cyc < 2800 && !in_valid && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b1;
        in_P = ref_mul(G, SCALAR_WIDTH'($urandom_range(0, 4)));
        case ($urandom_range(0, 3))
          0:       in_k = '0;
          1:       in_k = SCALAR_WIDTH'(1);
          default: in_k = SCALAR_WIDTH'($urandom);
        endcase
        in_tag = TAG_W'($urandom);
      end
      out_ready = (cyc >= 2800) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_jobs_done", 64'(jobs_done), 64'(exp_done));
      chk("rnd_jobs_err", 64'(jobs_err), 64'(exp_errs));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rnd_unexpected_result: got tag 0x%0h expected no result", out_tag);
        end else begin
          got = q.pop_front();
          chk("rnd_R", 64'(out_R), 64'(got.r));
          chk("rnd_tag", 64'(out_tag), 64'(got.tag));
          chk("rnd_err", 64'(out_err), 64'(got.err));
          exp_done++;
          if (got.err) exp_errs++;
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        e.tag = in_tag;
        e.err = 1'b0;
        if (in_k == '0) e.r = inf_point;
        else if (in_k == SCALAR_WIDTH'(1)) e.r = in_P;
        else begin
          d = int'($urandom_range(0, 20));
          eng_delay = d;
          if (d == 0 || d > int'(TIMEOUT)) begin
            e.r = inf_point;
            e.err = 1'b1;
          end else begin
            e.r = ref_mul(in_P, in_k);
          end
        end
        q.push_back(e);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("rnd_queue_drained", 64'(q.size()), 64'd0);
    chk("rnd_final_jobs_done", 64'(jobs_done), 64'(exp_done));
    chk("rnd_final_jobs_err", 64'(jobs_err), 64'(exp_errs));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/point_mul_issuer.md
Name: point_mul_issuer

Overview:
- Job-side driver for one scalar point-multiplication engine that uses the start/done protocol: engine reset pulse, wait for Done, then collect R.
- Accepts (P, k, tag) jobs on a valid/ready stream, runs each on the engine, and returns (R, tag, err) on a valid/ready result stream.
- Handles the trivial scalars k=0 and k=1 locally. Guards each job with a cycle timeout.
- Sits between the MSM scheduler and the point-multiplication engine.

Parameters:
- TAG_W, 8, width of the opaque job tag returned with each result.
- TIMEOUT, 4096, maximum WAIT cycles before a job is aborted with err=1; must be >= 2.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  job offered.
- in_ready  out  1  issuer accepts the job this cycle.
- in_P  in  curve_point_t  base point.
- in_k  in  SCALAR_WIDTH  scalar.
- in_tag  in  TAG_W  job tag.
- eng_Reset  out  1  engine start/reset; active-high.
- eng_P  out  curve_point_t  engine point operand; registered, stable for the whole job.
- eng_k  out  SCALAR_WIDTH  engine scalar operand; registered, stable for the whole job.
- eng_Done  in  1  engine completion.
- eng_R  in  curve_point_t  engine result; valid while eng_Done=1.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_R  out  curve_point_t  result point.
- out_tag  out  TAG_W  tag of the completed job.
- out_err  out  1  job hit the timeout; out_R = inf_point.
- jobs_done  out  CNT_W  count of results handed off, err included; wraps.
- jobs_err  out  CNT_W  count of timed-out results handed off; wraps.

Behaviour:
- Reset (Reset_n=0, async):
  - state=IDLE; eng_Reset=1; eng_P=inf_point; eng_k=0.
  - out_valid=0; out_R=inf_point; out_tag=0; out_err=0.
  - jobs_done=0; jobs_err=0; timer=0.
  - Asserting reset mid-job discards the job; no result is produced.
- eng_Reset is 1 in IDLE, START and RESP, and 0 only in WAIT. The engine therefore always sees at least one reset cycle with the new operands already stable.
- in_ready = (state==IDLE) | (state==RESP & out_ready). No combinational path from in_valid to in_ready.
- Accept occurs when in_valid & in_ready:
  - in_tag is latched.
  - k==0: out_R<=inf_point, out_err<=0, next state RESP. The engine is not started.
  - k==1: out_R<=in_P, out_err<=0, next state RESP. The engine is not started.
  - Otherwise: eng_P<=in_P, eng_k<=in_k, timer<=0, next state START.
- START: exactly one cycle, with eng_Reset=1. Next state WAIT.
- WAIT:
  - eng_Done is sampled only in this state. Done in any other state is ignored.
  - eng_Done=1: out_R<=eng_R, out_err<=0, next state RESP.
  - Otherwise, timer==TIMEOUT-1: out_R<=inf_point, out_err<=1, next state RESP.
  - Otherwise timer increments.
  - If eng_Done and the timeout coincide, Done wins and err=0.
- RESP:
  - out_valid=1; out_R, out_tag and out_err hold stable until out_ready.
  - On out_ready: jobs_done increments, and jobs_err increments if out_err=1.
  - If a new job is accepted in the same cycle, it is processed as in IDLE (back-to-back). Otherwise next state IDLE.
- Latency from accept to out_valid:
  - trivial scalar: 1 cycle;
  - engine job: 2 cycles plus the engine's Done delay measured from WAIT entry;
  - timeout: TIMEOUT+2 cycles.
- One job in flight; no reordering. Results appear in acceptance order.
- Statistics counters wrap modulo 2^CNT_W without saturation.
- Output-side backpressure may last indefinitely; nothing is dropped.

Decomposition:
- Existing package elliptic_curve_structs supplies curve_point_t, SCALAR_WIDTH and inf_point.
- Add to that package an enum issuer_state_t {IDLE, START, WAIT, RESP}.
- Single module. The timer and statistics counters are inline; no sub-module.
- The bench instantiates point_mul_issuer with a behavioural engine model of programmable Done delay, backed by the golden point-multiplication reference model.

Test Plan:
- Reset then idle: Reset_n low 3 cycles, release -> in_ready=1, out_valid=0, eng_Reset=1, counters 0.
- Engine job: P=G, k=2, tag=0x11, engine Done delay 5 cycles -> eng_Reset low for exactly 5 WAIT cycles; out_valid 7 cycles after accept; out_R=2G, out_tag=0x11, out_err=0; jobs_done=1.
- Trivial scalars: k=0 tag=1, then k=1 tag=2, out_ready held 1 -> results inf_point/tag 1 and G/tag 2, each 1 cycle after accept; eng_Reset never drops.
- Backpressure and back-to-back: out_ready=0 for 10 cycles with a second job pending -> in_ready=0 throughout and out_R/out_tag stable. Raise out_ready -> second job accepted in the same cycle, results in order.
- Timeout: TIMEOUT=16, engine never asserts Done -> out_err=1, out_R=inf_point, out_valid 18 cycles after accept; jobs_err=1. A Done asserted on the final WAIT cycle instead -> err=0 with the engine's R.
- Mid-job reset: assert Reset_n low during WAIT -> out_valid stays 0. After release, next job tag=0x22 k=3 -> returns 3G, tag 0x22; jobs_done=1.
